// File: rtl/pipe_stage_skid_if.sv
// Valid/ready bus between two pipeline stages: PC, payload, exception code, bad vaddr.
// The master side offers entries and the slave side answers with ready.
interface pipe_stage_skid_if #(
  parameter int DATA_W = 32,
  parameter int EXC_W  = 5
) ();
  logic              valid;
  logic              ready;
  logic [31:0]       pc;
  logic [DATA_W-1:0] data;
  logic [EXC_W-1:0]  exc_code;
  logic [31:0]       badvaddr;

  modport master (
    output valid, pc, data, exc_code, badvaddr,
    input  ready
  );

  modport slave (
    input  valid, pc, data, exc_code, badvaddr,
    output ready
  );
endinterface

// File: rtl/pipe_stage_skid.sv
// Inter-stage pipeline register with a valid/ready handshake on both sides and an optional
// 2-entry skid buffer. It drives a NOP bubble whenever it holds nothing.
module pipe_stage_skid #(
  parameter int                DATA_W   = 32,
  parameter int                EXC_W    = 5,
  parameter bit                SKID     = 1'b1,
  parameter logic [DATA_W-1:0] NOP_WORD = '0,
  parameter logic [EXC_W-1:0]  EC_NONE  = '0
) (
  input  logic                cpu_clk_75M,
  input  logic                cpu_rst_n,
  input  logic                flush,
  pipe_stage_skid_if.slave    up,
  pipe_stage_skid_if.master   dn,
  output logic [1:0]          occupancy
);

  typedef struct packed {
    logic [31:0]       pc;
    logic [DATA_W-1:0] data;
    logic [EXC_W-1:0]  exc;
    logic [31:0]       badvaddr;
  } entry_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  localparam entry_t BUBBLE = '{pc: 32'h0, data: NOP_WORD, exc: EC_NONE, badvaddr: 32'h0};

  state_e state_q, state_d;
  entry_t head_q, head_d;
  entry_t skid_q, skid_d;
  entry_t up_entry;
  logic   up_ready;
  logic   push;
  logic   pop;

  assign up_entry = '{pc: up.pc, data: up.data, exc: up.exc_code, badvaddr: up.badvaddr};

  // With the skid buffer, ready depends only on flops; without it, ready looks through to dn.ready.
  always_comb begin
    up_ready = 1'b0;
    if (SKID) begin
      up_ready = (state_q != FULL);
    end else begin
      up_ready = (state_q == EMPTY) | dn.ready;
    end
  end

  assign up.ready = up_ready;
  assign push     = up.valid & up_ready;
  assign pop      = (state_q != EMPTY) & dn.ready;

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = EMPTY;
      head_d  = BUBBLE;
      skid_d  = BUBBLE;
    end else begin
      case (state_q)
        EMPTY: begin
          if (push) begin
            state_d = ONE;
            head_d  = up_entry;
          end
        end
        ONE: begin
          if (push && pop) begin
            head_d = up_entry;
          end else if (push) begin
            // Only reachable with the skid buffer: ready without pop means S is free.
            state_d = FULL;
            skid_d  = up_entry;
          end else if (pop) begin
            state_d = EMPTY;
            head_d  = BUBBLE;
          end
        end
        FULL: begin
          if (pop) begin
            state_d = ONE;
            head_d  = skid_q;
            skid_d  = BUBBLE;
          end
        end
        default: begin
          state_d = EMPTY;
          head_d  = BUBBLE;
          skid_d  = BUBBLE;
        end
      endcase
    end
  end

  // Head/skid register stage
  always_ff @(posedge cpu_clk_75M or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      state_q <= EMPTY;
      head_q  <= BUBBLE;
      skid_q  <= BUBBLE;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      skid_q  <= skid_d;
    end
  end

  assign dn.valid    = (state_q != EMPTY);
  assign dn.pc       = head_q.pc;
  assign dn.data     = head_q.data;
  assign dn.exc_code = head_q.exc;
  assign dn.badvaddr = head_q.badvaddr;
  assign occupancy   = state_q;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: SKID=1 and SKID=0 instances share stimulus and are each
// compared every cycle with a queue model of the stage.
module tb_pipe_stage_skid;
  localparam int          DATA_W = 32;
  localparam int          EXC_W  = 5;
  localparam logic [31:0] NOP    = 32'h0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
    logic [4:0]  exc;
    logic [31:0] bva;
  } ent_t;

  typedef struct {
    logic        v;
    logic [31:0] pc;
    logic        dr;
    logic        fl;
    logic        er;
    logic        edv;
    logic [31:0] epc;
    logic [1:0]  eocc;
  } vec_t;

  localparam ent_t BUB = '{pc: 32'h0, data: NOP, exc: 5'h0, bva: 32'h0};

  logic       clk = 1'b0;
  logic       rst_n;
  logic       flush;
  logic [1:0] occ1, occ0;

  always #5 clk = ~clk;

  pipe_stage_skid_if #(.DATA_W(DATA_W), .EXC_W(EXC_W)) up1 ();
  pipe_stage_skid_if #(.DATA_W(DATA_W), .EXC_W(EXC_W)) dn1 ();
  pipe_stage_skid_if #(.DATA_W(DATA_W), .EXC_W(EXC_W)) up0 ();
  pipe_stage_skid_if #(.DATA_W(DATA_W), .EXC_W(EXC_W)) dn0 ();

  pipe_stage_skid #(.DATA_W(DATA_W), .EXC_W(EXC_W), .SKID(1'b1), .NOP_WORD(NOP)) dut1 (
    .cpu_clk_75M(clk), .cpu_rst_n(rst_n), .flush(flush),
    .up(up1), .dn(dn1), .occupancy(occ1)
  );

  pipe_stage_skid #(.DATA_W(DATA_W), .EXC_W(EXC_W), .SKID(1'b0), .NOP_WORD(NOP)) dut0 (
    .cpu_clk_75M(clk), .cpu_rst_n(rst_n), .flush(flush),
    .up(up0), .dn(dn0), .occupancy(occ0)
  );

  ent_t q1[$];
  ent_t q0[$];
  int   checks = 0;
  int   errors = 0;
  vec_t tbl[17];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic ent_t mk(input logic [31:0] pc);
    ent_t e;
    e.pc   = pc;
    e.data = ~pc;
    e.exc  = 5'h0;
    e.bva  = 32'h0;
    return e;
  endfunction

  task automatic drive(input logic v, input ent_t e, input logic dr, input logic fl);
    up1.valid = v;  up1.pc = e.pc;  up1.data = e.data;  up1.exc_code = e.exc;  up1.badvaddr = e.bva;
    up0.valid = v;  up0.pc = e.pc;  up0.data = e.data;  up0.exc_code = e.exc;  up0.badvaddr = e.bva;
    dn1.ready = dr;
    dn0.ready = dr;
    flush     = fl;
  endtask

  task automatic check_dn();
    ent_t h1, h0;
    h1 = (q1.size() > 0) ? q1[0] : BUB;
    h0 = (q0.size() > 0) ? q0[0] : BUB;
    chk("s1_dn_valid", dn1.valid, q1.size() > 0);
    chk("s1_dn_pc", dn1.pc, h1.pc);
    chk("s1_dn_data", dn1.data, h1.data);
    chk("s1_dn_exc", dn1.exc_code, h1.exc);
    chk("s1_dn_badvaddr", dn1.badvaddr, h1.bva);
    chk("s1_occupancy", occ1, q1.size());
    chk("s0_dn_valid", dn0.valid, q0.size() > 0);
    chk("s0_dn_pc", dn0.pc, h0.pc);
    chk("s0_dn_data", dn0.data, h0.data);
    chk("s0_dn_exc", dn0.exc_code, h0.exc);
    chk("s0_dn_badvaddr", dn0.badvaddr, h0.bva);
    chk("s0_occupancy", occ0, q0.size());
  endtask

  // One clock cycle: apply inputs, check ready before the edge, update models, check after.
  task automatic cyc(input logic v, input ent_t e, input logic dr, input logic fl, output logic r1);
    bit rdy1, rdy0, push1, push0, pop1, pop0;
    drive(v, e, dr, fl);
    #1;
    rdy1 = (q1.size() < 2);
    rdy0 = (q0.size() == 0) || dr;
    r1   = up1.ready;
    chk("s1_up_ready", up1.ready, rdy1);
    chk("s0_up_ready", up0.ready, rdy0);
    push1 = v && rdy1;
    push0 = v && rdy0;
    pop1  = (q1.size() > 0) && dr;
    pop0  = (q0.size() > 0) && dr;
    @(posedge clk);
    #1;
    if (fl) begin
      q1.delete();
      q0.delete();
    end else begin
      if (pop1) void'(q1.pop_front());
      if (push1) q1.push_back(e);
      if (pop0) void'(q0.pop_front());
      if (push0) q0.push_back(e);
    end
    check_dn();
  endtask

  initial begin
    logic        r;
    ent_t        e;
    logic [31:0] rnd;

    //              v     pc            dr    fl    rdy   dv    dn_pc         occ
    tbl[0]  = '{1'b1, 32'h1000, 1'b1, 1'b0, 1'b1, 1'b1, 32'h1000, 2'd1};
    tbl[1]  = '{1'b1, 32'h1004, 1'b1, 1'b0, 1'b1, 1'b1, 32'h1004, 2'd1};
    tbl[2]  = '{1'b1, 32'h1008, 1'b1, 1'b0, 1'b1, 1'b1, 32'h1008, 2'd1};
    tbl[3]  = '{1'b0, 32'h0,    1'b1, 1'b0, 1'b1, 1'b0, 32'h0,    2'd0};
    tbl[4]  = '{1'b1, 32'h2000, 1'b0, 1'b0, 1'b1, 1'b1, 32'h2000, 2'd1};
    tbl[5]  = '{1'b1, 32'h2004, 1'b0, 1'b0, 1'b1, 1'b1, 32'h2000, 2'd2};
    tbl[6]  = '{1'b1, 32'h2008, 1'b0, 1'b0, 1'b0, 1'b1, 32'h2000, 2'd2};
    tbl[7]  = '{1'b1, 32'h2008, 1'b1, 1'b0, 1'b0, 1'b1, 32'h2004, 2'd1};
    tbl[8]  = '{1'b1, 32'h2008, 1'b1, 1'b0, 1'b1, 1'b1, 32'h2008, 2'd1};
    tbl[9]  = '{1'b0, 32'h0,    1'b1, 1'b0, 1'b1, 1'b0, 32'h0,    2'd0};
    tbl[10] = '{1'b1, 32'h3000, 1'b0, 1'b0, 1'b1, 1'b1, 32'h3000, 2'd1};
    tbl[11] = '{1'b1, 32'h3004, 1'b0, 1'b0, 1'b1, 1'b1, 32'h3000, 2'd2};
    tbl[12] = '{1'b1, 32'h3008, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,    2'd0};
    tbl[13] = '{1'b0, 32'h0,    1'b1, 1'b0, 1'b1, 1'b0, 32'h0,    2'd0};
    tbl[14] = '{1'b1, 32'h4000, 1'b1, 1'b0, 1'b1, 1'b1, 32'h4000, 2'd1};
    tbl[15] = '{1'b1, 32'h4004, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0,    2'd0};
    tbl[16] = '{1'b0, 32'h0,    1'b1, 1'b0, 1'b1, 1'b0, 32'h0,    2'd0};

    rst_n = 1'b1;
    drive(1'b0, BUB, 1'b0, 1'b0);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_s1_dn_valid", dn1.valid, 1'b0);
    chk("rst_s1_dn_pc", dn1.pc, 32'h0);
    chk("rst_s1_dn_data", dn1.data, NOP);
    chk("rst_s1_occupancy", occ1, 2'd0);
    chk("rst_s0_dn_valid", dn0.valid, 1'b0);
    chk("rst_s0_occupancy", occ0, 2'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    chk("rst_release_s1_up_ready", up1.ready, 1'b1);
    chk("rst_release_s0_up_ready", up0.ready, 1'b1);

    for (int i = 0; i < 17; i++) begin
      cyc(tbl[i].v, mk(tbl[i].pc), tbl[i].dr, tbl[i].fl, r);
      chk($sformatf("vec%0d_up_ready", i), r, tbl[i].er);
      chk($sformatf("vec%0d_dn_valid", i), dn1.valid, tbl[i].edv);
      chk($sformatf("vec%0d_dn_pc", i), dn1.pc, tbl[i].epc);
      chk($sformatf("vec%0d_occupancy", i), occ1, tbl[i].eocc);
    end

    e = '{pc: 32'h5000, data: 32'hDEAD_BEEF, exc: 5'h04, bva: 32'hBFC0_0003};
    cyc(1'b1, e, 1'b0, 1'b0, r);
    chk("exc_s1_code", dn1.exc_code, 5'h04);
    chk("exc_s1_badvaddr", dn1.badvaddr, 32'hBFC0_0003);
    chk("exc_s0_code", dn0.exc_code, 5'h04);
    cyc(1'b0, BUB, 1'b1, 1'b0, r);
    chk("exc_pop_s1_code", dn1.exc_code, 5'h00);
    chk("exc_pop_s1_badvaddr", dn1.badvaddr, 32'h0);

    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, mk(32'h6000 + 32'(4 * i)), 1'b1, 1'b0, r);
      chk($sformatf("s0_stream%0d_pc", i), dn0.pc, 32'h6000 + 32'(4 * i));
    end
    cyc(1'b0, BUB, 1'b1, 1'b0, r);
    cyc(1'b1, mk(32'h7000), 1'b0, 1'b0, r);
    drive(1'b1, mk(32'h7004), 1'b0, 1'b0);
    #1 chk("s0_held_up_ready", up0.ready, 1'b0);
    drive(1'b1, mk(32'h7004), 1'b1, 1'b0);
    #1 chk("s0_pop_up_ready", up0.ready, 1'b1);
    cyc(1'b1, mk(32'h7004), 1'b1, 1'b0, r);
    chk("s0_pass_pc", dn0.pc, 32'h7004);
    cyc(1'b0, BUB, 1'b1, 1'b0, r);

    cyc(1'b1, mk(32'h8000), 1'b0, 1'b0, r);
    cyc(1'b1, mk(32'h8004), 1'b0, 1'b0, r);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_s1_dn_valid", dn1.valid, 1'b0);
    chk("midrst_s1_occupancy", occ1, 2'd0);
    chk("midrst_s1_dn_pc", dn1.pc, 32'h0);
    chk("midrst_s0_dn_valid", dn0.valid, 1'b0);
    q1.delete();
    q0.delete();
    drive(1'b0, BUB, 1'b0, 1'b0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    #1 chk("midrst_release_up_ready", up1.ready, 1'b1);

    for (int i = 0; i < 400; i++) begin
      rnd   = $urandom;
      e.pc  = $urandom;
      e.data = $urandom;
      e.exc = rnd[4:0];
      e.bva = $urandom;
      cyc(($urandom_range(0, 3) != 0), e, ($urandom_range(0, 2) != 0),
          ($urandom_range(0, 15) == 0), r);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
